// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between the debug host and the 6502 clock controller.
// CYCLE_COUNT_EN adds the completed-cycle counter to the status side.
interface cpu_clock_ctrl_if;
    logic        run;
    logic        halt_req;
    logic        step;
    logic        soft_reset;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] cpu_ab;
    logic        clk0;
    logic        res;
    logic        clk0_rise;
    logic        clk0_fall;
    logic        halted;
    logic        bp_hit;
`ifdef CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    modport master (
        output run, halt_req, step, soft_reset, bp_en, bp_addr, cpu_ab,
        input  clk0, res, clk0_rise, clk0_fall, halted, bp_hit, cycle_count
    );

    modport slave (
        input  run, halt_req, step, soft_reset, bp_en, bp_addr, cpu_ab,
        output clk0, res, clk0_rise, clk0_fall, halted, bp_hit, cycle_count
    );
`else
    modport master (
        output run, halt_req, step, soft_reset, bp_en, bp_addr, cpu_ab,
        input  clk0, res, clk0_rise, clk0_fall, halted, bp_hit
    );

    modport slave (
        input  run, halt_req, step, soft_reset, bp_en, bp_addr, cpu_ab,
        output clk0, res, clk0_rise, clk0_fall, halted, bp_hit
    );
`endif
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step clock and reset generator for the 6502 core, clk0 gated only at cycle boundaries.
// Optional feature macro: CYCLE_COUNT_EN (adds the 32-bit completed-cycle counter).
module cpu_clock_ctrl #(
    parameter int HALFCYCLE  = 8,
    parameter int RES_CYCLES = 8
) (
    input  logic            eclk,
    input  logic            ereset_n,
    cpu_clock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    localparam logic [7:0] HALF_M1_C = 8'(HALFCYCLE - 1);
    localparam logic [7:0] RES_M1_C  = 8'(RES_CYCLES - 1);

    function automatic logic bp_match(input logic en, input logic [15:0] ab, input logic [15:0] addr);
        return en && (ab == addr);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  i_r;
    logic [7:0]  rc_r;
    logic [7:0]  rc_nxt_s;
    logic        clk0_r;
    logic        res_r;
    logic        res_nxt_s;
    logic        rise_r;
    logic        fall_r;
    logic        bp_hit_r;
    logic        bp_hit_nxt_s;
    logic        bp_mask_r;
    logic        bp_mask_nxt_s;
    logic        halted_r;
    logic        engine_en_s;
    logic        tick_s;
    logic        fall_ev_s;
    logic        bp_term_s;
    logic        halt_cond_s;

    assign engine_en_s = (state_r != ST_HALT);
    assign tick_s      = engine_en_s && (i_r == HALF_M1_C);
    assign fall_ev_s   = tick_s && clk0_r;
    assign bp_term_s   = bp_match(bus.bp_en, bus.cpu_ab, bus.bp_addr) && !bp_mask_r;
    assign halt_cond_s = !bus.run || bus.halt_req || bp_term_s;

    // Phase counter and clk0 toggle, with one-eclk edge strobes
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            i_r    <= 8'd0;
            clk0_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= tick_s && !clk0_r;
            fall_r <= fall_ev_s;
            if (tick_s) begin
                i_r    <= 8'd0;
                clk0_r <= ~clk0_r;
            end else if (engine_en_s) begin
                i_r    <= i_r + 8'd1;
            end else begin
                i_r    <= i_r;
                clk0_r <= clk0_r;
            end
        end
    end

    // Sequencer next-state: decisions at fall events, HALT exits and soft_reset act immediately
    always_comb begin
        state_nxt_s   = state_r;
        rc_nxt_s      = rc_r;
        res_nxt_s     = res_r;
        bp_hit_nxt_s  = bp_hit_r;
        bp_mask_nxt_s = fall_ev_s ? 1'b0 : bp_mask_r;

        case (state_r)
            ST_RESET: begin
                res_nxt_s = 1'b0;
                if (fall_ev_s) begin
                    if (rc_r == RES_M1_C) begin
                        res_nxt_s   = 1'b1;
                        rc_nxt_s    = 8'd0;
                        state_nxt_s = (bus.run && !bus.halt_req) ? ST_RUN : ST_HALT;
                    end else begin
                        rc_nxt_s    = rc_r + 8'd1;
                    end
                end else begin
                    rc_nxt_s = rc_r;
                end
            end
            ST_RUN: begin
                if (fall_ev_s && halt_cond_s) begin
                    state_nxt_s  = ST_HALT;
                    bp_hit_nxt_s = bp_term_s;
                end else begin
                    state_nxt_s  = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.step) begin
                    state_nxt_s   = ST_STEP;
                    bp_hit_nxt_s  = 1'b0;
                    bp_mask_nxt_s = 1'b1;
                end else if (bus.run && !bus.halt_req) begin
                    state_nxt_s   = ST_RUN;
                    bp_hit_nxt_s  = 1'b0;
                    bp_mask_nxt_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_HALT;
                end
            end
            ST_STEP: begin
                if (fall_ev_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            default: begin
                state_nxt_s = ST_RESET;
                rc_nxt_s    = 8'd0;
                res_nxt_s   = 1'b0;
            end
        endcase

        // soft_reset wins over everything; the clock engine is deliberately left alone
        if (bus.soft_reset) begin
            state_nxt_s  = ST_RESET;
            rc_nxt_s     = 8'd0;
            res_nxt_s    = 1'b0;
            bp_hit_nxt_s = 1'b0;
            if (state_r == ST_HALT) begin
                bp_mask_nxt_s = 1'b1;
            end else begin
                bp_mask_nxt_s = bp_mask_nxt_s;
            end
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Sequencer state and registered status outputs
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_r   <= ST_RESET;
            rc_r      <= 8'd0;
            res_r     <= 1'b0;
            bp_hit_r  <= 1'b0;
            bp_mask_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rc_r      <= rc_nxt_s;
            res_r     <= res_nxt_s;
            bp_hit_r  <= bp_hit_nxt_s;
            bp_mask_r <= bp_mask_nxt_s;
            halted_r  <= (state_nxt_s == ST_HALT);
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cycle_count_r;

    // Completed CPU cycles while the core is out of reset; wraps naturally
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            cycle_count_r <= 32'd0;
        end else if (fall_ev_s && res_r) begin
            cycle_count_r <= cycle_count_r + 32'd1;
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign bus.cycle_count = cycle_count_r;
`endif

    assign bus.clk0      = clk0_r;
    assign bus.res       = res_r;
    assign bus.clk0_rise = rise_r;
    assign bus.clk0_fall = fall_r;
    assign bus.halted    = halted_r;
    assign bus.bp_hit    = bp_hit_r;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with HALFCYCLE=4, RES_CYCLES=3: vector table plus corner-case sequences.
// CYCLE_COUNT_EN enables the cycle_count checks.
module tb_cpu_clock_ctrl;

    logic eclk;
    logic ereset_n;
    int   n_cmp;
    int   n_err;

    cpu_clock_ctrl_if bus ();

    cpu_clock_ctrl #(.HALFCYCLE(4), .RES_CYCLES(3)) dut (
        .eclk     (eclk),
        .ereset_n (ereset_n),
        .bus      (bus)
    );

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    typedef struct {
        logic        run;
        logic        halt_req;
        logic        step;
        logic        bp_en;
        logic [15:0] cpu_ab;
        int          n;
        logic        e_clk0;
        logic        e_res;
        logic        e_halted;
        logic        e_bp_hit;
        logic        e_rise;
        logic        e_fall;
    } vec_t;

    vec_t vec[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge eclk);
        #1;
    endtask

    task automatic hold_reset();
        ereset_n = 1'b0;
        tick(2);
        ereset_n = 1'b1;
    endtask

    int rises;
    int falls;
    int highs;

    initial begin
        n_cmp = 0;
        n_err = 0;
        // run halt step bp_en cpu_ab n | clk0 res halted bp_hit rise fall
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,  16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000,   1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFC,   8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFC,   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFC,   8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFC,   8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000,   1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        bus.run        = 1'b1;
        bus.halt_req   = 1'b0;
        bus.step       = 1'b0;
        bus.soft_reset = 1'b0;
        bus.bp_en      = 1'b0;
        bus.bp_addr    = 16'hFFFC;
        bus.cpu_ab     = 16'h0000;
        ereset_n       = 1'b0;
        tick(2);
        chk("rst_clk0", {31'd0, bus.clk0}, 32'd0);
        chk("rst_res", {31'd0, bus.res}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_bp_hit", {31'd0, bus.bp_hit}, 32'd0);
        chk("rst_strobes", {30'd0, bus.clk0_rise, bus.clk0_fall}, 32'd0);
`ifdef CYCLE_COUNT_EN
        chk("rst_cycle_count", bus.cycle_count, 32'd0);
`endif
        ereset_n = 1'b1;

        // Reset sequence into RUN, boundary-only sampling, breakpoint halt and resume
        for (int v = 0; v < 13; v++) begin
            bus.run      = vec[v].run;
            bus.halt_req = vec[v].halt_req;
            bus.step     = vec[v].step;
            bus.bp_en    = vec[v].bp_en;
            bus.cpu_ab   = vec[v].cpu_ab;
            tick(vec[v].n);
            bus.step     = 1'b0;
            bus.halt_req = 1'b0;
            chk($sformatf("v%0d_clk0", v), {31'd0, bus.clk0}, {31'd0, vec[v].e_clk0});
            chk($sformatf("v%0d_res", v), {31'd0, bus.res}, {31'd0, vec[v].e_res});
            chk($sformatf("v%0d_halted", v), {31'd0, bus.halted}, {31'd0, vec[v].e_halted});
            chk($sformatf("v%0d_bp_hit", v), {31'd0, bus.bp_hit}, {31'd0, vec[v].e_bp_hit});
            chk($sformatf("v%0d_rise", v), {31'd0, bus.clk0_rise}, {31'd0, vec[v].e_rise});
            chk($sformatf("v%0d_fall", v), {31'd0, bus.clk0_fall}, {31'd0, vec[v].e_fall});
        end

        // Single step from HALT, with a second step pulse ignored mid-step
        rises = 0;
        falls = 0;
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        chk("step_enter_halted", {31'd0, bus.halted}, 32'd0);
        chk("step_bp_hit_clr", {31'd0, bus.bp_hit}, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            bus.step = (k == 3) ? 1'b1 : 1'b0;
            tick(1);
            bus.step = 1'b0;
            rises += int'(bus.clk0_rise);
            falls += int'(bus.clk0_fall);
            if (k == 4) chk("step_clk0_high", {31'd0, bus.clk0}, 32'd1);
            if (k == 7) chk("step_still_running", {31'd0, bus.halted}, 32'd0);
            if (k == 8) chk("step_halted_again", {31'd0, bus.halted}, 32'd1);
        end
        chk("step_rises", rises, 32'd1);
        chk("step_falls", falls, 32'd1);
        chk("step_end_halted", {31'd0, bus.halted}, 32'd1);

        // Reset with run=0 lands in HALT and the clock stays stopped
        bus.run = 1'b0;
        hold_reset();
        tick(24);
        chk("r0_res", {31'd0, bus.res}, 32'd1);
        chk("r0_halted", {31'd0, bus.halted}, 32'd1);
        chk("r0_fall", {31'd0, bus.clk0_fall}, 32'd1);
        rises = 0;
        falls = 0;
        highs = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            rises += int'(bus.clk0_rise);
            falls += int'(bus.clk0_fall);
            highs += int'(bus.clk0);
        end
        chk("r0_strobes", rises + falls, 32'd0);
        chk("r0_clk0_low", highs, 32'd0);
        chk("r0_still_halted", {31'd0, bus.halted}, 32'd1);

        // soft_reset in RUN keeps the clk0 phase and reruns the res count
        bus.run = 1'b1;
        tick(1);
        chk("sr_run_halted", {31'd0, bus.halted}, 32'd0);
        tick(9);
        bus.soft_reset = 1'b1;
        tick(1);
        bus.soft_reset = 1'b0;
        chk("sr_res_low", {31'd0, bus.res}, 32'd0);
        chk("sr_clk0", {31'd0, bus.clk0}, 32'd0);
        tick(2);
        chk("sr_phase_rise", {31'd0, bus.clk0_rise}, 32'd1);
        chk("sr_phase_clk0", {31'd0, bus.clk0}, 32'd1);
        tick(19);
        chk("sr_res_still_low", {31'd0, bus.res}, 32'd0);
        tick(1);
        chk("sr_res_high", {31'd0, bus.res}, 32'd1);
        chk("sr_fall", {31'd0, bus.clk0_fall}, 32'd1);

        // Asynchronous reset in the middle of a clk0-high phase
        tick(5);
        chk("ar_pre_clk0", {31'd0, bus.clk0}, 32'd1);
        #2;
        ereset_n = 1'b0;
        #1;
        chk("ar_clk0", {31'd0, bus.clk0}, 32'd0);
        chk("ar_res", {31'd0, bus.res}, 32'd0);
        chk("ar_halted", {31'd0, bus.halted}, 32'd0);

        // Ten cycles of RUN, a long HALT, then one step
        bus.run = 1'b1;
        hold_reset();
        tick(24);
        chk("cc_res", {31'd0, bus.res}, 32'd1);
        tick(79);
        bus.run = 1'b0;
        tick(1);
        chk("cc_halted", {31'd0, bus.halted}, 32'd1);
`ifdef CYCLE_COUNT_EN
        chk("cc_ten", bus.cycle_count, 32'd10);
`endif
        tick(50);
`ifdef CYCLE_COUNT_EN
        chk("cc_hold", bus.cycle_count, 32'd10);
`endif
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        tick(8);
        chk("cc_step_halted", {31'd0, bus.halted}, 32'd1);
`ifdef CYCLE_COUNT_EN
        chk("cc_eleven", bus.cycle_count, 32'd11);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
